// File: rtl/ccff_chain_loader.sv
// Streams bitstream words MSB-first onto a configuration chain, CRC-checks the loaded bits
// against a trailing CRC word and collects a readback signature of what leaves the chain.
module ccff_chain_loader #(
  parameter int          CHAIN_LEN = 1024,
  parameter int          WORD_W    = 32,
  parameter logic [15:0] CRC_INIT  = 16'hFFFF
) (
  input  logic              prog_clk,
  input  logic              pReset_n,
  input  logic              start,
  input  logic              abort,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [WORD_W-1:0] s_data,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              config_enable,
  output logic              cfg_clk_en,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [15:0]       tail_crc
);

  localparam int CNT_W = $clog2(CHAIN_LEN + 1);
  localparam int BUF_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_C = CNT_W'(CHAIN_LEN);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SHIFT = 3'd1,
    ST_CHECK = 3'd2,
    ST_DONE  = 3'd3,
    ST_ERR   = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] buf_q, buf_d;
  logic [BUF_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0]       head_crc_q, head_crc_d;
  logic [15:0]       tail_crc_q, tail_crc_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              shifting_s;
  logic              s_ready_s;

  function automatic logic [15:0] crc_step(input logic [15:0] crc, input logic b);
    logic fb;
    fb = crc[15] ^ b;
    return {crc[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  // Bits of a new word that still fit in the chain, given the count after this cycle's shift.
  function automatic logic [BUF_W-1:0] avail_bits(input logic [CNT_W-1:0] bit_cnt);
    logic [31:0] rem;
    rem = 32'(LAST_C - bit_cnt);
    if (rem < 32'(WORD_W)) begin
      return BUF_W'(rem);
    end else begin
      return BUF_W'(WORD_W);
    end
  endfunction

  assign shifting_s = (state_q == ST_SHIFT) && (cnt_q != '0);
  // Refill on the last buffered bit avoids a bubble, except when that bit ends the chain.
  assign s_ready_s  = (state_q == ST_CHECK) ||
                      ((state_q == ST_SHIFT) &&
                       ((cnt_q == '0) ||
                        ((cnt_q == BUF_W'(1)) && (bit_cnt_q != LAST_C - CNT_W'(1)))));

  always_comb begin
    state_d    = state_q;
    buf_d      = buf_q;
    cnt_d      = cnt_q;
    bit_cnt_d  = bit_cnt_q;
    head_crc_d = head_crc_q;
    tail_crc_d = tail_crc_q;
    done_d     = done_q;
    err_d      = err_q;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_SHIFT;
          buf_d      = '0;
          cnt_d      = '0;
          bit_cnt_d  = '0;
          head_crc_d = CRC_INIT;
          tail_crc_d = CRC_INIT;
          done_d     = 1'b0;
          err_d      = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      ST_SHIFT: begin
        if (abort) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
          cnt_d   = '0;
        end else begin
          if (shifting_s) begin
            head_crc_d = crc_step(head_crc_q, buf_q[WORD_W-1]);
            tail_crc_d = crc_step(tail_crc_q, ccff_tail);
            buf_d      = {buf_q[WORD_W-2:0], 1'b0};
            cnt_d      = cnt_q - BUF_W'(1);
            bit_cnt_d  = bit_cnt_q + CNT_W'(1);
          end else begin
            buf_d = buf_q;
          end
          if (s_valid && s_ready_s) begin
            buf_d = s_data;
            cnt_d = avail_bits(bit_cnt_d);
          end else begin
            cnt_d = cnt_d;
          end
          if (bit_cnt_d == LAST_C) begin
            state_d = ST_CHECK;
          end else begin
            state_d = ST_SHIFT;
          end
        end
      end
      ST_CHECK: begin
        if (abort) begin
          state_d = ST_ERR;
          err_d   = 1'b1;
        end else if (s_valid) begin
          if (s_data[15:0] == head_crc_q) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_ERR;
            err_d   = 1'b1;
          end
        end else begin
          state_d = ST_CHECK;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge prog_clk or negedge pReset_n) begin
    if (!pReset_n) begin
      state_q    <= ST_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      bit_cnt_q  <= '0;
      head_crc_q <= CRC_INIT;
      tail_crc_q <= CRC_INIT;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      head_crc_q <= head_crc_d;
      tail_crc_q <= tail_crc_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign s_ready       = s_ready_s;
  assign ccff_head     = shifting_s ? buf_q[WORD_W-1] : 1'b0;
  assign cfg_clk_en    = shifting_s;
  assign config_enable = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign busy          = (state_q == ST_SHIFT) || (state_q == ST_CHECK);
  assign done          = done_q;
  assign err           = err_q;
  assign tail_crc      = tail_crc_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Scoreboard bench for ccff_chain_loader: a 20-bit chain model feeds ccff_tail, a monitor
// compares every shifted head bit and every load outcome against queued expectations.
module tb_ccff_chain_loader;

  localparam int CL = 20;
  localparam int WW = 16;

  logic          prog_clk = 1'b0;
  logic          pReset_n = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic          s_valid = 1'b0;
  logic [WW-1:0] s_data = 16'h0000;
  logic          s_ready, ccff_head, ccff_tail, config_enable, cfg_clk_en, busy, done, err;
  logic [15:0]   tail_crc;
  logic [CL-1:0] chain_q = '0;

  int total = 0;
  int bad = 0;
  int shift_cnt = 0;
  int stall_cnt = 0;
  bit exp_bits[$];
  logic [1:0] exp_status[$];

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW), .CRC_INIT(16'hFFFF)) dut (
    .prog_clk(prog_clk), .pReset_n(pReset_n), .start(start), .abort(abort),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .config_enable(config_enable),
    .cfg_clk_en(cfg_clk_en), .busy(busy), .done(done), .err(err), .tail_crc(tail_crc)
  );

  always #5 prog_clk = ~prog_clk;

  // Chain model: ccff_tail is the bit shifted in CL gated cycles earlier.
  assign ccff_tail = chain_q[CL-1];
  always @(posedge prog_clk) begin
    if (cfg_clk_en) chain_q <= {chain_q[CL-2:0], ccff_head};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model_crc(input logic [19:0] bits);
    logic [15:0] c;
    logic fb;
    c = 16'hFFFF;
    for (int i = 19; i >= 0; i--) begin
      fb = c[15] ^ bits[i];
      c = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  // Monitor: pops an expected bit on each gated cycle and an expected outcome when busy falls.
  initial begin : monitor
    logic busy_prev;
    bit b;
    logic [1:0] st;
    busy_prev = 1'b0;
    forever begin
      @(negedge prog_clk);
      if (!pReset_n) begin
        busy_prev = 1'b0;
      end else begin
        if (cfg_clk_en) begin
          shift_cnt++;
          if (exp_bits.size() == 0) begin
            check("unexpected_shift", 32'd1, 32'd0);
          end else begin
            b = exp_bits.pop_front();
            check("ccff_head", 32'(ccff_head), 32'(b));
          end
        end else if (busy && shift_cnt > 0 && exp_bits.size() > 0) begin
          stall_cnt++;
        end
        if (busy_prev && !busy) begin
          if (exp_status.size() == 0) begin
            check("unexpected_end", 32'd1, 32'd0);
          end else begin
            st = exp_status.pop_front();
            check("done_err", 32'({done, err}), 32'(st));
          end
        end
        busy_prev = busy;
      end
    end
  end

  task automatic pulse_start();
    @(posedge prog_clk); #1;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
  endtask

  // Call between a rising edge and the next falling edge; returns 1 ns after the accepting edge.
  task automatic send_word(input logic [15:0] w);
    bit ok;
    ok = 1'b0;
    s_valid = 1'b1;
    s_data = w;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge prog_clk);
      if (s_ready) ok = 1'b1;
    end
    if (!ok) check("s_ready_timeout", 32'd0, 32'd1);
    @(posedge prog_clk); #1;
    s_valid = 1'b0;
    s_data = 16'h0000;
  endtask

  task automatic push_bits(input logic [19:0] bits);
    for (int i = 19; i >= 0; i--) exp_bits.push_back(bits[i]);
    shift_cnt = 0;
    stall_cnt = 0;
  endtask

  task automatic run_load(input string tag, input logic [15:0] w0, input logic [15:0] w1,
                          input logic [19:0] bits, input logic [15:0] crc_xor,
                          input int gap, input int exp_stall);
    push_bits(bits);
    exp_status.push_back((crc_xor == 16'h0000) ? 2'b10 : 2'b01);
    pulse_start();
    #3;
    check($sformatf("%s_start_busy", tag), 32'(busy), 32'd1);
    check($sformatf("%s_start_cleared", tag), 32'({done, err}), 32'd0);
    send_word(w0);
    if (gap > 0) begin
      repeat (gap) @(posedge prog_clk);
      #1;
    end
    send_word(w1);
    send_word(model_crc(bits) ^ crc_xor);
    @(negedge prog_clk);
    check($sformatf("%s_busy", tag), 32'(busy), 32'd0);
    check($sformatf("%s_cfg_en", tag), 32'(config_enable), 32'd0);
    check($sformatf("%s_shifts", tag), 32'(shift_cnt), 32'd20);
    check($sformatf("%s_stalls", tag), 32'(stall_cnt), 32'(exp_stall));
    check($sformatf("%s_bits_left", tag), 32'(exp_bits.size()), 32'd0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    @(posedge prog_clk); #1;
    check("rst_outputs", 32'({s_ready, ccff_head, config_enable, cfg_clk_en, busy, done, err}), 32'd0);
    check("rst_tail_crc", 32'(tail_crc), 32'hFFFF);
    @(posedge prog_clk); #1;
    pReset_n = 1'b1;

    // Basic load, then the same data with a corrupted CRC word.
    run_load("T1", 16'hA5C3, 16'hF0FF, 20'hA5C3F, 16'h0000, 0, 0);
    run_load("T2", 16'hA5C3, 16'hF0FF, 20'hA5C3F, 16'h0001, 0, 0);

    // Five empty-buffer cycles between the words.
    run_load("T3", 16'hA5C3, 16'hF0FF, 20'hA5C3F, 16'h0000, 20, 5);

    // Abort during the seventh shift cycle.
    push_bits(20'hA5C3F);
    exp_status.push_back(2'b01);
    pulse_start();
    #3;
    send_word(16'hA5C3);
    repeat (6) @(posedge prog_clk);
    #1;
    abort = 1'b1;
    @(posedge prog_clk); #1;
    abort = 1'b0;
    @(negedge prog_clk);
    check("T4_err", 32'(err), 32'd1);
    check("T4_busy", 32'(busy), 32'd0);
    check("T4_enables", 32'({config_enable, cfg_clk_en}), 32'd0);
    check("T4_shifts", 32'(shift_cnt), 32'd7);
    check("T4_bits_left", 32'(exp_bits.size()), 32'd13);
    exp_bits.delete();
    run_load("T4b", 16'hA5C3, 16'hF0FF, 20'hA5C3F, 16'h0000, 0, 0);

    // Readback: loading B pushes pattern A out of the chain.
    run_load("T5a", 16'hA5C3, 16'hF0FF, 20'hA5C3F, 16'h0000, 0, 0);
    run_load("T5b", 16'h3C96, 16'h5ABC, 20'h3C965, 16'h0000, 0, 0);
    check("T5_tail_crc", 32'(tail_crc), 32'(model_crc(20'hA5C3F)));
    repeat (3) @(posedge prog_clk);
    #1;
    check("T5_tail_crc_hold", 32'(tail_crc), 32'(model_crc(20'hA5C3F)));

    // Asynchronous reset in the middle of shifting.
    push_bits(20'hA5C3F);
    pulse_start();
    #3;
    send_word(16'hA5C3);
    repeat (3) @(posedge prog_clk);
    #3;
    check("T6_pre_shift", 32'(cfg_clk_en), 32'd1);
    pReset_n = 1'b0;
    #1;
    check("T6_rst_outputs", 32'({s_ready, ccff_head, config_enable, cfg_clk_en, busy, done, err}), 32'd0);
    check("T6_rst_tail_crc", 32'(tail_crc), 32'hFFFF);
    exp_bits.delete();
    repeat (2) @(posedge prog_clk);
    #1;
    pReset_n = 1'b1;
    run_load("T6", 16'hA5C3, 16'hF0FF, 20'hA5C3F, 16'h0000, 0, 0);

    repeat (3) @(posedge prog_clk);
    check("status_queue_empty", 32'(exp_status.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
